// File: rtl/c_fork_split5_pkg.sv
// Shared definitions for the five-way fork/split controller.
//   state_t : controller state encoding (2 bits)
//   N_CH    : number of downstream channels
package c_fork_split5_pkg;

  localparam int N_CH = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/c_free_collect.sv
// Pending-mask register that tracks which downstream channels still owe
// a free pulse.
//   clk, rstn  : clock, asynchronous active-low reset
//   set_all    : load the mask with all ones (token accepted)
//   clr_en     : per-bit clears are honoured this cycle
//   clr        : per-channel clear requests
//   pending    : current mask
//   all_clear  : mask becomes zero as a result of this cycle's clears
//   dup_clr    : a clear hit a bit that was already zero
module c_free_collect
  import c_fork_split5_pkg::*;
#(
  parameter int N = N_CH
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         set_all,
  input  logic         clr_en,
  input  logic [N-1:0] clr,
  output logic [N-1:0] pending,
  output logic         all_clear,
  output logic         dup_clr
);

  logic [N-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending & ~clr;
    all_clear   = clr_en && (pending_nxt == '0);
    // Valid and duplicate clears in the same cycle are independent: the
    // valid bits still clear while the duplicate is flagged.
    dup_clr     = clr_en && (|(clr & ~pending));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
    end else if (set_all) begin
      pending <= '1;
    end else if (clr_en) begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/c_fork_split5.sv
// Five-way fork/split controller with drive/free pulse handshake.
// Accepts one upstream token, slices its data into five registered
// channels, pulses every downstream drive, then waits for all five
// downstream frees (any order) before returning one upstream free.
//
//   clk, rstn          : clock, asynchronous active-low reset
//   i_drive, i_data    : upstream token pulse and {ch4,ch3,ch2,ch1,ch0} data
//   o_free             : upstream free pulse
//   o_driveK, o_dataK  : downstream drive pulse and data slice, K = 0..4
//   i_freeK            : downstream free pulse, K = 0..4
//   o_busy             : token in flight
//   o_err              : sticky protocol-error flag
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no token; accept i_drive
// ST_WAIT    | drives issued; collecting downstream frees
// ST_RELEASE | o_free pulse cycle; a new i_drive is accepted as in IDLE
module c_fork_split5
  import c_fork_split5_pkg::*;
#(
  parameter  int DATA_WIDTH_O0 = 1,
  parameter  int DATA_WIDTH_O1 = 3,
  parameter  int DATA_WIDTH_O2 = 3,
  parameter  int DATA_WIDTH_O3 = 3,
  parameter  int DATA_WIDTH_O4 = 1,
  localparam int DW_TOT = DATA_WIDTH_O0 + DATA_WIDTH_O1 + DATA_WIDTH_O2
                        + DATA_WIDTH_O3 + DATA_WIDTH_O4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_drive,
  input  logic [DW_TOT-1:0]        i_data,
  output logic                     o_free,
  output logic                     o_drive0,
  output logic                     o_drive1,
  output logic                     o_drive2,
  output logic                     o_drive3,
  output logic                     o_drive4,
  output logic [DATA_WIDTH_O0-1:0] o_data0,
  output logic [DATA_WIDTH_O1-1:0] o_data1,
  output logic [DATA_WIDTH_O2-1:0] o_data2,
  output logic [DATA_WIDTH_O3-1:0] o_data3,
  output logic [DATA_WIDTH_O4-1:0] o_data4,
  input  logic                     i_free0,
  input  logic                     i_free1,
  input  logic                     i_free2,
  input  logic                     i_free3,
  input  logic                     i_free4,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int OFF1 = DATA_WIDTH_O0;
  localparam int OFF2 = OFF1 + DATA_WIDTH_O1;
  localparam int OFF3 = OFF2 + DATA_WIDTH_O2;
  localparam int OFF4 = OFF3 + DATA_WIDTH_O3;

  state_t          state;
  logic            drive_q;
  logic [N_CH-1:0] free_vec;
  logic [N_CH-1:0] pending;
  logic            in_wait;
  logic            accept;
  logic            all_clear;
  logic            dup_clr;
  logic            err_evt;

  always_comb begin
    free_vec = {i_free4, i_free3, i_free2, i_free1, i_free0};
    in_wait  = (state == ST_WAIT);
    accept   = i_drive && ((state == ST_IDLE) || (state == ST_RELEASE));
    // Drive while busy, duplicate free in WAIT, or any free outside WAIT.
    err_evt  = (in_wait && (i_drive || dup_clr)) || (!in_wait && (|free_vec));
  end

  c_free_collect #(
    .N (N_CH)
  ) u_free_collect (
    .clk       (clk),
    .rstn      (rstn),
    .set_all   (accept),
    .clr_en    (in_wait),
    .clr       (free_vec),
    .pending   (pending),
    .all_clear (all_clear),
    .dup_clr   (dup_clr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      drive_q <= 1'b0;
      o_free  <= 1'b0;
      o_busy  <= 1'b0;
      o_err   <= 1'b0;
      o_data0 <= '0;
      o_data1 <= '0;
      o_data2 <= '0;
      o_data3 <= '0;
      o_data4 <= '0;
    end else begin
      drive_q <= 1'b0;
      o_free  <= 1'b0;
      case (state)
        ST_IDLE, ST_RELEASE: begin
          if (accept) begin
            o_data0 <= i_data[0    +: DATA_WIDTH_O0];
            o_data1 <= i_data[OFF1 +: DATA_WIDTH_O1];
            o_data2 <= i_data[OFF2 +: DATA_WIDTH_O2];
            o_data3 <= i_data[OFF3 +: DATA_WIDTH_O3];
            o_data4 <= i_data[OFF4 +: DATA_WIDTH_O4];
            drive_q <= 1'b1;
            o_busy  <= 1'b1;
            state   <= ST_WAIT;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (all_clear) begin
            o_free <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_RELEASE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
      if (err_evt) begin
        o_err <= 1'b1;
      end
    end
  end

  // One shared drive register fans out to all five channels.
  assign o_drive0 = drive_q;
  assign o_drive1 = drive_q;
  assign o_drive2 = drive_q;
  assign o_drive3 = drive_q;
  assign o_drive4 = drive_q;

  // pending is consumed inside the collector; kept visible for debug.
  logic unused_pending;
  assign unused_pending = |pending;

endmodule

// File: tb/tb_c_fork_split5.sv
module tb_c_fork_split5;

  typedef struct {
    logic       e0;
    logic [2:0] e1;
    logic [2:0] e2;
    logic [2:0] e3;
    logic       e4;
  } exp_t;

  typedef struct {
    logic [10:0]     data;
    exp_t            ex;
    logic            once;
    int              gap;
    logic [4:0][2:0] order;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_drive = 1'b0;
  logic [10:0] i_data = '0;
  logic [4:0]  free_v = '0;
  logic        o_free, o_busy, o_err;
  logic        o_drive0, o_drive1, o_drive2, o_drive3, o_drive4;
  logic        o_data0, o_data4;
  logic [2:0]  o_data1, o_data2, o_data3;

  int   n_vec = 0;
  int   n_mis = 0;
  int   free_cnt = 0;
  exp_t exp_q[$];
  vec_t vt[6];

  c_fork_split5 dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_drive  (i_drive),
    .i_data   (i_data),
    .o_free   (o_free),
    .o_drive0 (o_drive0),
    .o_drive1 (o_drive1),
    .o_drive2 (o_drive2),
    .o_drive3 (o_drive3),
    .o_drive4 (o_drive4),
    .o_data0  (o_data0),
    .o_data1  (o_data1),
    .o_data2  (o_data2),
    .o_data3  (o_data3),
    .o_data4  (o_data4),
    .i_free0  (free_v[0]),
    .i_free1  (free_v[1]),
    .i_free2  (free_v[2]),
    .i_free3  (free_v[3]),
    .i_free4  (free_v[4]),
    .o_busy   (o_busy),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_exp(input logic e0, input logic [2:0] e1, input logic [2:0] e2,
                                  input logic [2:0] e3, input logic e4);
    exp_t e;
    e.e0 = e0; e.e1 = e1; e.e2 = e2; e.e3 = e3; e.e4 = e4;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [10:0] d, input exp_t ex, input logic once,
                                  input int gap, input logic [4:0][2:0] order);
    vec_t v;
    v.data = d; v.ex = ex; v.once = once; v.gap = gap; v.order = order;
    return v;
  endfunction

  // Scoreboard: every drive pulse must match the oldest pending token.
  always @(negedge clk) begin
    logic [4:0] drv;
    exp_t e;
    drv = {o_drive4, o_drive3, o_drive2, o_drive1, o_drive0};
    if (o_free) free_cnt++;
    if (drv != 5'd0) begin
      check("drive_all", {27'd0, drv}, 32'h1f);
      check("sb_token_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data0", {31'd0, o_data0}, {31'd0, e.e0});
        check("data1", {29'd0, o_data1}, {29'd0, e.e1});
        check("data2", {29'd0, o_data2}, {29'd0, e.e2});
        check("data3", {29'd0, o_data3}, {29'd0, e.e3});
        check("data4", {31'd0, o_data4}, {31'd0, e.e4});
      end
    end
  end

  task automatic reset_check(input string tag);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_free"}, {31'd0, o_free}, 32'd0);
    check({tag, "_err"}, {31'd0, o_err}, 32'd0);
    check({tag, "_drive"}, {27'd0, o_drive4, o_drive3, o_drive2, o_drive1, o_drive0}, 32'd0);
    check({tag, "_data"}, {21'd0, o_data4, o_data3, o_data2, o_data1, o_data0}, 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    reset_check("rst");
    step();
    rstn = 1'b1;
    step();
  endtask

  // Runs one token from an IDLE cycle to the IDLE cycle after RELEASE.
  task automatic run_vec(input vec_t v, input logic exp_err);
    int fc0;
    fc0 = free_cnt;
    i_drive = 1'b1;
    i_data  = v.data;
    exp_q.push_back(v.ex);
    step();
    i_drive = 1'b0;
    check("busy_wait", {31'd0, o_busy}, 32'd1);
    if (v.once) begin
      free_v = 5'h1f;
      step();
      free_v = '0;
    end else begin
      repeat (v.gap) begin
        step();
        check("free_early", {31'd0, o_free}, 32'd0);
      end
      for (int k = 0; k < 5; k++) begin
        free_v = 5'd1 << v.order[k];
        step();
        free_v = '0;
        if (k < 4) begin
          check("free_early", {31'd0, o_free}, 32'd0);
          check("busy_hold", {31'd0, o_busy}, 32'd1);
        end
      end
    end
    check("free_pulse", {31'd0, o_free}, 32'd1);
    check("busy_release", {31'd0, o_busy}, 32'd0);
    step();
    check("free_single", {31'd0, o_free}, 32'd0);
    check("free_count", free_cnt - fc0, 32'd1);
    check("err_flag", {31'd0, o_err}, {31'd0, exp_err});
  endtask

  initial begin
    vt[0] = mk_vec(11'b1_101_011_110_0, mk_exp(1'b0, 3'b110, 3'b011, 3'b101, 1'b1), 1'b0, 2,
                   {3'd3, 3'd1, 3'd0, 3'd2, 3'd4});
    vt[1] = mk_vec(11'h7FF, mk_exp(1'b1, 3'b111, 3'b111, 3'b111, 1'b1), 1'b1, 0,
                   {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
    vt[2] = mk_vec(11'h000, mk_exp(1'b0, 3'b000, 3'b000, 3'b000, 1'b0), 1'b0, 0,
                   {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
    vt[3] = mk_vec(11'b0_010_100_001_1, mk_exp(1'b1, 3'b001, 3'b100, 3'b010, 1'b0), 1'b0, 1,
                   {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    vt[4] = mk_vec(11'b1_000_111_000_0, mk_exp(1'b0, 3'b000, 3'b111, 3'b000, 1'b1), 1'b1, 0,
                   {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
    vt[5] = mk_vec(11'b0_111_000_101_1, mk_exp(1'b1, 3'b101, 3'b000, 3'b111, 1'b0), 1'b0, 0,
                   {3'd0, 3'd3, 3'd1, 3'd4, 3'd2});

    repeat (3) step();
    reset_check("init");
    rstn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_vec(vt[i], 1'b0);
    end

    // Back-to-back: second token accepted in the RELEASE cycle.
    i_drive = 1'b1;
    i_data  = 11'h2A5;
    exp_q.push_back(mk_exp(1'b1, 3'b010, 3'b010, 3'b101, 1'b0));
    step();
    i_drive = 1'b0;
    free_v  = 5'h1f;
    step();
    free_v  = '0;
    check("b2b_free1", {31'd0, o_free}, 32'd1);
    i_drive = 1'b1;
    i_data  = 11'h7FF;
    exp_q.push_back(mk_exp(1'b1, 3'b111, 3'b111, 3'b111, 1'b1));
    step();
    i_drive = 1'b0;
    check("b2b_busy", {31'd0, o_busy}, 32'd1);
    check("b2b_data1", {29'd0, o_data1}, 32'd7);
    check("b2b_drive", {31'd0, o_drive0}, 32'd1);
    free_v = 5'h1f;
    step();
    free_v = '0;
    check("b2b_free2", {31'd0, o_free}, 32'd1);
    step();
    check("b2b_err", {31'd0, o_err}, 32'd0);

    // Drive while busy: dropped, data held, error flagged.
    begin
      int fc0;
      fc0 = free_cnt;
      i_drive = 1'b1;
      i_data  = vt[3].data;
      exp_q.push_back(vt[3].ex);
      step();
      i_drive = 1'b0;
      step();
      i_drive = 1'b1;
      i_data  = 11'h7FF;
      step();
      i_drive = 1'b0;
      check("busy_drv_err", {31'd0, o_err}, 32'd1);
      check("busy_drv_data1", {29'd0, o_data1}, 32'b001);
      check("busy_drv_data3", {29'd0, o_data3}, 32'b010);
      check("busy_drv_busy", {31'd0, o_busy}, 32'd1);
      for (int k = 0; k < 5; k++) begin
        free_v = 5'd1 << k;
        step();
        free_v = '0;
      end
      check("busy_drv_free", {31'd0, o_free}, 32'd1);
      repeat (3) step();
      check("busy_drv_free_cnt", free_cnt - fc0, 32'd1);
      check("busy_drv_idle", {31'd0, o_busy}, 32'd0);
    end
    do_reset();

    // Duplicate free, plus a valid free in the same cycle as a duplicate.
    i_drive = 1'b1;
    i_data  = vt[0].data;
    exp_q.push_back(vt[0].ex);
    step();
    i_drive = 1'b0;
    free_v  = 5'b00100;
    step();
    check("dup_err_pre", {31'd0, o_err}, 32'd0);
    free_v  = 5'b00101;
    step();
    free_v  = 5'b00010;
    check("dup_err", {31'd0, o_err}, 32'd1);
    check("dup_nofree", {31'd0, o_free}, 32'd0);
    step();
    free_v  = 5'b01000;
    check("dup_nofree1", {31'd0, o_free}, 32'd0);
    step();
    free_v  = 5'b10000;
    check("dup_nofree3", {31'd0, o_free}, 32'd0);
    step();
    free_v  = '0;
    check("dup_free", {31'd0, o_free}, 32'd1);
    step();
    do_reset();

    // Stray free in IDLE, then a full token still completes normally.
    free_v = 5'b00001;
    step();
    free_v = '0;
    check("stray_err", {31'd0, o_err}, 32'd1);
    check("stray_busy", {31'd0, o_busy}, 32'd0);
    check("stray_free", {31'd0, o_free}, 32'd0);
    run_vec(vt[2], 1'b1);
    do_reset();

    // Reset mid-token with three frees collected.
    i_drive = 1'b1;
    i_data  = vt[5].data;
    exp_q.push_back(vt[5].ex);
    step();
    i_drive = 1'b0;
    for (int k = 0; k < 3; k++) begin
      free_v = 5'd1 << k;
      step();
      free_v = '0;
    end
    check("mid_busy_pre", {31'd0, o_busy}, 32'd1);
    do_reset();
    i_drive = 1'b1;
    i_data  = vt[4].data;
    exp_q.push_back(vt[4].ex);
    step();
    i_drive = 1'b0;
    free_v  = 5'b11000;
    step();
    free_v  = '0;
    step();
    step();
    check("mid_nofree", {31'd0, o_free}, 32'd0);
    check("mid_busy", {31'd0, o_busy}, 32'd1);
    free_v = 5'b00111;
    step();
    free_v = '0;
    check("mid_free", {31'd0, o_free}, 32'd1);
    check("mid_err", {31'd0, o_err}, 32'd0);
    step();

    check("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
